// File: rtl/heap_request_sequencer.sv
// heap_request_sequencer
// Bridges a valid/ready request channel onto the heap Memory block. Each
// accepted request is presented to the heap for one full clock, struck with
// a single heap_clock transition, allowed to settle, then captured and
// returned on a valid/ready response channel. An operation counter and a
// sticky error flag summarise activity since reset.
module heap_request_sequencer #(
    parameter int ADDRESS_BITS  = 2,
    parameter int INDEX_BITS    = 1,
    parameter int DATA_BITS     = 12,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                    clock,
    input  logic                    reset,

    // request channel
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [7:0]              req_action,
    input  logic [ADDRESS_BITS-1:0] req_array,
    input  logic [INDEX_BITS-1:0]   req_index,
    input  logic [DATA_BITS-1:0]    req_in,

    // response channel
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_BITS-1:0]    rsp_out,
    output logic [31:0]             rsp_error,

    // heap Memory interface
    output logic                    heap_clock,
    output logic [7:0]              heap_action,
    output logic [ADDRESS_BITS-1:0] heap_array,
    output logic [INDEX_BITS-1:0]   heap_index,
    output logic [DATA_BITS-1:0]    heap_in,
    input  logic [DATA_BITS-1:0]    heap_out,
    input  logic [31:0]             heap_error,

    // status
    output logic                    busy,
    output logic [31:0]             ops_done,
    output logic                    error_seen
);

    // The settle counter is four bits wide, so only 1..15 can be honoured.
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_settle_range_check
        $fatal(1, "heap_request_sequencer: SETTLE_CYCLES must be in 1..15");
    end

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        SETTLE  = 2'd2,
        RESPOND = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    // One-cycle strobes decoded from the current state and handshakes.
    logic        do_accept;
    logic        do_strike;
    logic        do_capture;
    logic        do_retire;

    logic [3:0]  cnt;
    logic [31:0] ops_done_q;

    // Status decodes are purely combinational on the state register.
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign ops_done  = ops_done_q;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and per-state action strobes.
    always_comb begin
        state_next = state;
        do_accept  = 1'b0;
        do_strike  = 1'b0;
        do_capture = 1'b0;
        do_retire  = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    do_accept  = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                // Operands have now been stable on heap_* for a full clock.
                do_strike  = 1'b1;
                state_next = SETTLE;
            end
            SETTLE: begin
                if (cnt == 4'd1) begin
                    do_capture = 1'b1;
                    state_next = RESPOND;
                end
            end
            RESPOND: begin
                // rsp_ready may already be high; the handshake completes here.
                if (rsp_ready) begin
                    do_retire  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Heap operand latch and strobe. Operands hold until the next accept so
    // the heap never sees a change outside a request; heap_clock is only
    // touched on the SETUP->SETTLE step (and by reset, where action 0 makes
    // any resulting edge harmless).
    always_ff @(posedge clock) begin
        if (reset) begin
            heap_clock  <= 1'b0;
            heap_action <= 8'd0;
            heap_array  <= '0;
            heap_index  <= '0;
            heap_in     <= '0;
        end else begin
            if (do_accept) begin
                heap_action <= req_action;
                heap_array  <= req_array;
                heap_index  <= req_index;
                heap_in     <= req_in;
            end
            if (do_strike) begin
                heap_clock <= ~heap_clock;
            end
        end
    end

    // Settle countdown: loaded on the strike, decremented while settling.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= 4'd0;
        end else if (do_strike) begin
            cnt <= SETTLE_INIT;
        end else if (state == SETTLE) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Response capture and release. Captured values stay put while the
    // consumer applies backpressure.
    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_out   <= '0;
            rsp_error <= 32'd0;
        end else begin
            if (do_capture) begin
                rsp_valid <= 1'b1;
                rsp_out   <= heap_out;
                rsp_error <= heap_error;
            end else if (do_retire) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    // Completed-operation counter (free-running wrap) and sticky error flag.
    // Both advance at capture so an aborted operation leaves no trace.
    always_ff @(posedge clock) begin
        if (reset) begin
            ops_done_q <= 32'd0;
            error_seen <= 1'b0;
        end else if (do_capture) begin
            ops_done_q <= ops_done_q + 32'd1;
            if (heap_error != 32'd0) begin
                error_seen <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_heap_request_sequencer.sv
// Self-checking bench for heap_request_sequencer: a scoreboard queue holds
// the expected response of every issued request; a monitor pops and
// compares on every response handshake.
module tb_heap_request_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    // main instance, SETTLE_CYCLES = 1
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_action = 8'd0;
    logic [1:0]  req_array = 2'd0;
    logic [0:0]  req_index = 1'b0;
    logic [11:0] req_in = 12'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [11:0] rsp_out;
    logic [31:0] rsp_error;
    logic        heap_clock;
    logic [7:0]  heap_action;
    logic [1:0]  heap_array;
    logic [0:0]  heap_index;
    logic [11:0] heap_in;
    logic [11:0] heap_out = 12'd0;
    logic [31:0] heap_error = 32'd0;
    logic        busy;
    logic [31:0] ops_done;
    logic        error_seen;

    // second instance, SETTLE_CYCLES = 3
    logic        r6_valid = 1'b0;
    logic        r6_ready;
    logic [7:0]  r6_action = 8'd0;
    logic [1:0]  r6_array = 2'd0;
    logic [0:0]  r6_index = 1'b0;
    logic [11:0] r6_in = 12'd0;
    logic        s6_valid;
    logic        s6_ready = 1'b1;
    logic [11:0] s6_out;
    logic [31:0] s6_error;
    logic        h6_clock;
    logic [7:0]  h6_action;
    logic [1:0]  h6_array;
    logic [0:0]  h6_index;
    logic [11:0] h6_in;
    logic [11:0] h6_out = 12'd0;
    logic [31:0] h6_error = 32'd0;
    logic        busy6;
    logic [31:0] ops6;
    logic        err6;

    int checks = 0;
    int errors = 0;
    int toggles = 0;
    int toggles6 = 0;
    time tog_t[$];

    typedef struct {
        logic [11:0] out;
        logic [31:0] err;
    } rsp_t;
    rsp_t sb[$];

    heap_request_sequencer #(
        .ADDRESS_BITS(2), .INDEX_BITS(1), .DATA_BITS(12), .SETTLE_CYCLES(1)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_action(req_action),
        .req_array(req_array), .req_index(req_index), .req_in(req_in),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_out(rsp_out),
        .rsp_error(rsp_error),
        .heap_clock(heap_clock), .heap_action(heap_action), .heap_array(heap_array),
        .heap_index(heap_index), .heap_in(heap_in), .heap_out(heap_out),
        .heap_error(heap_error),
        .busy(busy), .ops_done(ops_done), .error_seen(error_seen)
    );

    heap_request_sequencer #(
        .ADDRESS_BITS(2), .INDEX_BITS(1), .DATA_BITS(12), .SETTLE_CYCLES(3)
    ) dut6 (
        .clock(clock), .reset(reset),
        .req_valid(r6_valid), .req_ready(r6_ready), .req_action(r6_action),
        .req_array(r6_array), .req_index(r6_index), .req_in(r6_in),
        .rsp_valid(s6_valid), .rsp_ready(s6_ready), .rsp_out(s6_out),
        .rsp_error(s6_error),
        .heap_clock(h6_clock), .heap_action(h6_action), .heap_array(h6_array),
        .heap_index(h6_index), .heap_in(h6_in), .heap_out(h6_out),
        .heap_error(h6_error),
        .busy(busy6), .ops_done(ops6), .error_seen(err6)
    );

    always #5 clock = ~clock;

    // Heap model: acts on either heap_clock edge; error scripted by action.
    always @(heap_clock) begin
        heap_out   = heap_in + 12'(heap_action);
        heap_error = (heap_action == 8'd11) ? 32'd100000274 : 32'd0;
        if (!reset) begin
            toggles++;
            tog_t.push_back($time);
        end
    end

    always @(h6_clock) begin
        h6_out   = h6_in + 12'(h6_action);
        h6_error = (h6_action == 8'd11) ? 32'd100000274 : 32'd0;
        if (!reset) toggles6++;
    end

    // Monitor: compare every response that completes a handshake.
    always @(negedge clock) begin
        if (!reset && rsp_valid && rsp_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got out=%0h err=%0d with no expected response", rsp_out, rsp_error);
            end else begin
                rsp_t e;
                e = sb.pop_front();
                if (rsp_out !== e.out || rsp_error !== e.err) begin
                    errors++;
                    $display("FAIL rsp_data: got out=%0h err=%0d expected out=%0h err=%0d",
                             rsp_out, rsp_error, e.out, e.err);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] a, input logic [1:0] arr, input logic idx,
                        input logic [11:0] din, input logic [11:0] eo,
                        input logic [31:0] ee, input bit expect_rsp);
        int n;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        if (!req_ready) begin
            chk("req_ready_timeout", 64'(req_ready), 64'd1);
        end else begin
            req_valid  = 1'b1;
            req_action = a;
            req_array  = arr;
            req_index  = idx;
            req_in     = din;
            if (expect_rsp) sb.push_back('{out: eo, err: ee});
            @(posedge clock); #1;
            req_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        if (busy) chk("idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    logic [7:0]  v_act [8] = '{8'h01, 8'h02, 8'h03, 8'h10, 8'hFF, 8'hFF, 8'h07, 8'h80};
    logic [11:0] v_in  [8] = '{12'h000, 12'h0FE, 12'h7FD, 12'h123, 12'hF00, 12'hF01, 12'hAA0, 12'h080};
    logic [11:0] v_exp [8] = '{12'h001, 12'h100, 12'h800, 12'h133, 12'hFFF, 12'h000, 12'hAA7, 12'h100};

    initial begin
        int t0;
        int n;
        do_reset();

        // reset state
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_out", 64'(rsp_out), 64'd0);
        chk("rst_rsp_error", 64'(rsp_error), 64'd0);
        chk("rst_ops_done", 64'(ops_done), 64'd0);
        chk("rst_error_seen", 64'(error_seen), 64'd0);
        chk("rst_heap_clock", 64'(heap_clock), 64'd0);
        chk("rst_heap_action", 64'(heap_action), 64'd0);
        chk("rst_heap_in", 64'(heap_in), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);

        // 1: single op with rsp_ready already high
        rsp_ready = 1'b1;
        send(8'd4, 2'd2, 1'b1, 12'h010, 12'h014, 32'd0, 1'b1);
        chk("t1_busy_setup", 64'(busy), 64'd1);
        chk("t1_req_ready_setup", 64'(req_ready), 64'd0);
        @(posedge clock); #1;
        chk("t1_valid_e1", 64'(rsp_valid), 64'd0);
        chk("t1_toggles_e1", 64'(toggles), 64'd1);
        @(posedge clock); #1;
        chk("t1_valid_e2", 64'(rsp_valid), 64'd1);
        chk("t1_ops_done", 64'(ops_done), 64'd1);
        wait_idle();
        chk("t1_toggles_end", 64'(toggles), 64'd1);
        chk("t1_hold_action", 64'(heap_action), 64'd4);
        chk("t1_hold_array", 64'(heap_array), 64'd2);
        chk("t1_hold_index", 64'(heap_index), 64'd1);
        chk("t1_hold_in", 64'(heap_in), 64'h010);
        chk("t1_rsp_valid_done", 64'(rsp_valid), 64'd0);

        // 2: backpressure, with a stray request held on the input meanwhile
        rsp_ready = 1'b0;
        send(8'd5, 2'd1, 1'b0, 12'h0F0, 12'h0F5, 32'd0, 1'b1);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        chk("t2_valid_seen", 64'(rsp_valid), 64'd1);
        t0 = toggles;
        req_valid = 1'b1;
        req_action = 8'h33;
        req_in = 12'h555;
        repeat (5) begin
            @(posedge clock); #1;
            chk("t2_hold_valid", 64'(rsp_valid), 64'd1);
            chk("t2_hold_out", 64'(rsp_out), 64'h0F5);
            chk("t2_req_ready", 64'(req_ready), 64'd0);
            chk("t2_no_toggle", 64'(toggles), 64'(t0));
            chk("t2_heap_in_hold", 64'(heap_in), 64'h0F0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle();
        chk("t2_ops_done", 64'(ops_done), 64'd2);
        chk("t2_toggles", 64'(toggles), 64'd2);

        // 3: heap error, then a clean op that wraps the data path
        send(8'd11, 2'd3, 1'b0, 12'h100, 12'h10B, 32'd100000274, 1'b1);
        wait_idle();
        chk("t3_error_seen", 64'(error_seen), 64'd1);
        chk("t3_rsp_error", 64'(rsp_error), 64'd100000274);
        send(8'd1, 2'd0, 1'b1, 12'hFFF, 12'h000, 32'd0, 1'b1);
        wait_idle();
        chk("t3_next_ops", 64'(ops_done), 64'd4);
        chk("t3_sticky", 64'(error_seen), 64'd1);
        chk("t3_next_err", 64'(rsp_error), 64'd0);

        // 4: back-to-back stream
        do_reset();
        chk("t4_error_cleared", 64'(error_seen), 64'd0);
        tog_t.delete();
        t0 = toggles;
        for (int i = 0; i < 8; i++) begin
            send(v_act[i], 2'(i), 1'(i), v_in[i], v_exp[i], 32'd0, 1'b1);
        end
        wait_idle();
        chk("t4_ops_done", 64'(ops_done), 64'd8);
        chk("t4_toggles", 64'(toggles - t0), 64'd8);
        if (tog_t.size() == 8) begin
            for (int i = 1; i < 8; i++) begin
                chk("t4_spacing", 64'(tog_t[i] - tog_t[i-1]), 64'd40);
            end
        end else begin
            chk("t4_toggle_times", 64'(tog_t.size()), 64'd8);
        end

        // 5: reset while settling aborts the op
        send(8'd9, 2'd1, 1'b1, 12'h200, 12'h000, 32'd0, 1'b0);
        @(posedge clock); #1;
        chk("t5_in_settle", 64'(busy), 64'd1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("t5_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("t5_ops_done", 64'(ops_done), 64'd0);
        chk("t5_heap_action", 64'(heap_action), 64'd0);
        chk("t5_idle", 64'(req_ready), 64'd1);
        chk("t5_busy", 64'(busy), 64'd0);

        // 6: SETTLE_CYCLES = 3 latency and counter wrap
        force dut6.ops_done_q = 32'hFFFFFFFF;
        @(posedge clock); #1;
        release dut6.ops_done_q;
        @(posedge clock); #1;
        chk("t6_preset", 64'(ops6), 64'hFFFFFFFF);
        chk("t6_ready", 64'(r6_ready), 64'd1);
        r6_valid = 1'b1;
        r6_action = 8'd2;
        r6_array = 2'd1;
        r6_index = 1'b0;
        r6_in = 12'h005;
        @(posedge clock); #1;
        r6_valid = 1'b0;
        @(posedge clock); #1;
        chk("t6_valid_e1", 64'(s6_valid), 64'd0);
        chk("t6_toggle_e1", 64'(toggles6), 64'd1);
        @(posedge clock); #1;
        chk("t6_valid_e2", 64'(s6_valid), 64'd0);
        @(posedge clock); #1;
        chk("t6_valid_e3", 64'(s6_valid), 64'd0);
        @(posedge clock); #1;
        chk("t6_valid_e4", 64'(s6_valid), 64'd1);
        chk("t6_out", 64'(s6_out), 64'h007);
        chk("t6_wrap", 64'(ops6), 64'd0);
        @(posedge clock); #1;
        chk("t6_done", 64'(s6_valid), 64'd0);
        chk("t6_toggle_total", 64'(toggles6), 64'd1);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
